dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the core's memory stage: consumes the core's dcache_addr, dcache_re, dcache_we and dcache_din, and returns dcache_dout and stall.
- Backed by a word-wide main-memory request/response port; misses are refilled as a burst of line-length beats.

Parameters:
- SETS, 64, number of lines; power of 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address; bits [1:0] ignored for indexing
- cpu_re  in  1  read request
- cpu_we  in  4  byte write enables; nonzero means write request
- cpu_din  in  32  store data, already lane-aligned
- cpu_dout  out  32  load data
- stall  out  1  core must freeze and hold its request while high
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = write, 0 = line read
- mem_req_addr  out  32  word-aligned address (line-aligned for reads)
- mem_req_data  out  32  write data
- mem_req_mask  out  4  write byte mask
- mem_resp_valid  in  1  one read beat valid
- mem_resp_data  in  32  read beat data

Behaviour:
- Address split, with OFF = log2(WORDS_PER_LINE)+2 and IDX = log2(SETS):
  - word select = addr[OFF-1:2]
  - index = addr[OFF+IDX-1:OFF]
  - tag = addr[31:OFF+IDX]
- Storage: data, tag and valid bit per line. Only valid bits are reset.
- Reset values: all valid bits 0; state IDLE; cpu_dout=0; stall=0; mem_req_valid=0; mem_req_rw=0; mem_req_addr=0; mem_req_data=0; mem_req_mask=0.
- Request acceptance and priority:
  - A request is accepted at a posedge with stall=0 and (cpu_re=1 or cpu_we≠0).
  - If both cpu_re and cpu_we are asserted, the request is a write; cpu_dout is not updated.
- States:
  - IDLE:
    - Read hit: cpu_dout holds the word in the cycle after acceptance; stall=0 (1-cycle latency).
    - Read miss → REFILL_REQ.
    - Write (hit or miss) → WR_REQ. A write hit also merges the cpu_we bytes into the line at acceptance. A write miss does not allocate.
  - WR_REQ: mem_req_valid=1, rw=1, addr={addr[31:2],2'b00}, data=cpu_din, mask=cpu_we. On mem_req_ready → IDLE.
  - REFILL_REQ: mem_req_valid=1, rw=0, addr = line base. On mem_req_ready → REFILL_WAIT with beat counter 0.
  - REFILL_WAIT:
    - Each mem_resp_valid writes beat k to word k and increments the counter.
    - After the last beat: set valid and tag, update cpu_dout with the requested word, → IDLE.
- Stall timing:
  - stall is high from the cycle after a missing read or any write is accepted, until the cycle the cache returns to IDLE. It is combinational from state.
  - Minimum penalty: write 1 cycle; refill 2 + WORDS_PER_LINE cycles.
- mem_req_valid, once raised, stays high with all fields stable until mem_req_ready.
- mem_resp_valid outside REFILL_WAIT is ignored.
- cpu_dout holds its last value across writes and stall cycles.
- Asynchronous reset mid-refill or mid-write: aborts immediately, all lines become invalid, state → IDLE. Any beats arriving after reset are ignored.
- Back-to-back hits: one accepted per cycle, no bubbles.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each accepted read hit.
  - miss_count increments on each accepted read miss.
  - Both counters wrap modulo 2^32; writes are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold read miss:
  - Stimulus: read 0x0000_1004; memory returns 0xA0,0xA1,0xA2,0xA3.
  - Required: one request with addr 0x0000_1000, rw=0; stall high 6 cycles with zero-latency memory; cpu_dout=0xA1.
- Hit after refill:
  - Stimulus: reads 0x1000, 0x1008, 0x100C back-to-back.
  - Required: stall stays 0; cpu_dout is 0xA0, 0xA2, 0xA3 on consecutive cycles.
- Write hit:
  - Stimulus: write 0x1004, we=4'b0010, din=0x0000_BB00, then read 0x1004.
  - Required: memory sees rw=1, mask=0010; read returns 0x0000_BBA1 with no miss.
- Write miss:
  - Stimulus: write 0x2000 (not cached), then read 0x2000.
  - Required: write-through only, no allocation; the read misses and refills.
- Conflict eviction:
  - Stimulus: read 0x1000, then 0x1000 + SETS·WORDS_PER_LINE·4 (0x1400), then 0x1000.
  - Required: three refills.
- Reset mid-refill:
  - Stimulus: assert reset after beat 2 of 4.
  - Required: stall=0 and mem_req_valid=0 immediately; a subsequent read of the same line misses; with DCACHE_STATS_EN both counters read 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking direct-mapped write-through no-write-allocate data cache
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int WB  = $clog2(WORDS_PER_LINE);
    localparam int OFF = WB + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 32 - OFF - IDX;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);

    typedef enum logic [1:0] {IDLE, WR_REQ, REFILL_REQ, REFILL_WAIT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     din_q, din_d;
    logic [3:0]      we_q, we_d;
    logic [WB:0]     cnt_q, cnt_d;
    logic [31:0]     dout_q, dout_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [31:0]     data_q [SETS*WORDS_PER_LINE];
    logic [TW-1:0]   tag_q [SETS];

    logic [IDX-1:0]    cur_idx, ref_idx;
    logic [IDX+WB-1:0] cur_w, ref_w;
    logic              is_wr, accept, hit, wr_hit, rd_acc, beat_wr, fill_done;

    assign cur_idx   = cpu_addr[OFF+IDX-1:OFF];
    assign cur_w     = cpu_addr[OFF+IDX-1:2];
    assign ref_idx   = addr_q[OFF+IDX-1:OFF];
    assign ref_w     = addr_q[OFF+IDX-1:2];
    assign is_wr     = |cpu_we;
    assign accept    = (state_q == IDLE) && (cpu_re || is_wr);
    assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cpu_addr[31:OFF+IDX]);
    assign wr_hit    = accept && is_wr && hit;
    assign rd_acc    = accept && !is_wr;
    // the counter's top bit marks "all beats in"; the line is published one cycle later
    assign beat_wr   = (state_q == REFILL_WAIT) && !cnt_q[WB] && mem_resp_valid;
    assign fill_done = (state_q == REFILL_WAIT) && cnt_q[WB];

    assign cpu_dout      = dout_q;
    assign stall         = state_q != IDLE;
    assign mem_req_valid = (state_q == WR_REQ) || (state_q == REFILL_REQ);
    assign mem_req_rw    = state_q == WR_REQ;
    assign mem_req_addr  = (state_q == WR_REQ) ? (addr_q & 32'hFFFF_FFFC) :
                           (state_q == REFILL_REQ) ? (addr_q & LINE_MASK) : 32'd0;
    assign mem_req_data  = (state_q == WR_REQ) ? din_q : 32'd0;
    assign mem_req_mask  = (state_q == WR_REQ) ? we_q : 4'd0;

    // next-state and request capture; the request is latched so memory fields stay stable
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (accept) begin
                addr_d = cpu_addr;
                din_d  = cpu_din;
                we_d   = cpu_we;
                if (is_wr) state_d = WR_REQ;
                else if (hit) dout_d = data_q[cur_w];
                else state_d = REFILL_REQ;
            end
            WR_REQ: state_d = mem_req_ready ? IDLE : WR_REQ;
            REFILL_REQ: if (mem_req_ready) begin
                state_d = REFILL_WAIT;
                cnt_d   = '0;
            end
            REFILL_WAIT: if (fill_done) begin
                valid_d[ref_idx] = 1'b1;
                dout_d           = data_q[ref_w];
                state_d          = IDLE;
            end else if (mem_resp_valid) cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // control state; only valid bits among the storage are cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // data and tag arrays: store-hit byte merge, refill beats, tag on line completion
    always_ff @(posedge clk) begin
        if (wr_hit)
            for (int b = 0; b < 4; b++)
                if (cpu_we[b]) data_q[cur_w][8*b +: 8] <= cpu_din[8*b +: 8];
        if (beat_wr) data_q[{ref_idx, cnt_q[WB-1:0]}] <= mem_resp_data;
        if (fill_done) tag_q[ref_idx] <= addr_q[31:OFF+IDX];
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // accepted reads are classified at acceptance; writes are never counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (rd_acc && hit) hit_q <= hit_q + 32'd1;
            if (rd_acc && !hit) miss_q <= miss_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven directed bench for dcache_ctrl with a zero-latency memory model
module tb_dcache_ctrl;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_ctrl #(.SETS(64), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        int          exp_stall;
        int          exp_refills;
    } vec_t;

    vec_t        vecs [13];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [logic [31:0]];
    int          rd_reqs = 0;
    int          wr_reqs = 0;
    logic [31:0] last_raddr = '0, last_waddr = '0, last_wdata = '0, rbase = '0;
    logic [3:0]  last_wmask = '0;
    int          beats_left = 0;
    int          beat_idx = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : mem_init(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory: captures requests the cycle before the accepting edge, streams beats afterwards
    always @(negedge clk) begin
        logic [31:0] w;
        if (beats_left > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_rd(rbase + 32'(beat_idx * 4));
            beat_idx++;
            beats_left--;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        if (mem_req_valid && mem_req_ready && !reset) begin
            if (mem_req_rw) begin
                wr_reqs++;
                last_waddr = mem_req_addr;
                last_wdata = mem_req_data;
                last_wmask = mem_req_mask;
                w = mem_rd(mem_req_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_req_mask[b]) w[8*b +: 8] = mem_req_data[8*b +: 8];
                mem[mem_req_addr] = w;
            end else begin
                rd_reqs++;
                last_raddr = mem_req_addr;
                rbase      = mem_req_addr;
                beat_idx   = 0;
                beats_left = WPL;
            end
        end
    end

    task automatic xact(input logic [31:0] a, input logic re, input logic [3:0] we,
                        input logic [31:0] din, output int stalls);
        cpu_addr = a;
        cpu_re   = re;
        cpu_we   = we;
        cpu_din  = din;
        @(posedge clk);
        #1;
        stalls = 0;
        while (stall && stalls < 50) begin
            stalls++;
            @(posedge clk);
            #1;
        end
        cpu_re = 1'b0;
        cpu_we = '0;
    endtask

    initial begin
        int st, r0, w0;
        vecs[0]  = '{32'h1004, 1'b1, 4'h0, 32'h0,         32'h0000_00A1, 6, 1};
        vecs[1]  = '{32'h1000, 1'b1, 4'h0, 32'h0,         32'h0000_00A0, 0, 0};
        vecs[2]  = '{32'h1008, 1'b1, 4'h0, 32'h0,         32'h0000_00A2, 0, 0};
        vecs[3]  = '{32'h100C, 1'b1, 4'h0, 32'h0,         32'h0000_00A3, 0, 0};
        vecs[4]  = '{32'h1004, 1'b0, 4'h2, 32'h0000_BB00, 32'h0000_00A3, 1, 0};
        vecs[5]  = '{32'h1004, 1'b1, 4'h0, 32'h0,         32'h0000_BBA1, 0, 0};
        vecs[6]  = '{32'h2000, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0000_BBA1, 1, 0};
        vecs[7]  = '{32'h2000, 1'b1, 4'h0, 32'h0,         32'hDEAD_BEEF, 6, 1};
        vecs[8]  = '{32'h1400, 1'b1, 4'h0, 32'h0,         32'h0000_01A0, 6, 1};
        vecs[9]  = '{32'h1000, 1'b1, 4'h0, 32'h0,         32'h0000_00A0, 6, 1};
        vecs[10] = '{32'h1004, 1'b1, 4'h0, 32'h0,         32'h0000_BBA1, 0, 0};
        vecs[11] = '{32'h1008, 1'b1, 4'h1, 32'h0000_0055, 32'h0000_BBA1, 1, 0};
        vecs[12] = '{32'h1008, 1'b1, 4'h0, 32'h0,         32'h0000_0055, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset_dout", cpu_dout, 32'd0);
        check("reset_req_addr", mem_req_addr, 32'd0);
        check("reset_req_rw", 32'(mem_req_rw), 32'd0);

        for (int i = 0; i < 13; i++) begin
            r0 = rd_reqs;
            w0 = wr_reqs;
            xact(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].din, st);
            check($sformatf("v%0d_dout", i), cpu_dout, vecs[i].exp_dout);
            check($sformatf("v%0d_stall_cycles", i), 32'(st), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d_refills", i), 32'(rd_reqs - r0), 32'(vecs[i].exp_refills));
            if (vecs[i].exp_refills > 0)
                check($sformatf("v%0d_refill_addr", i), last_raddr, vecs[i].addr & 32'hFFFF_FFF0);
            if (vecs[i].we != 4'h0) begin
                check($sformatf("v%0d_writes", i), 32'(wr_reqs - w0), 32'd1);
                check($sformatf("v%0d_wr_addr", i), last_waddr, vecs[i].addr & 32'hFFFF_FFFC);
                check($sformatf("v%0d_wr_data", i), last_wdata, vecs[i].din);
                check($sformatf("v%0d_wr_mask", i), 32'(last_wmask), 32'(vecs[i].we));
            end
        end

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'd6);
        check("miss_count", miss_count, 32'd4);
`endif

        w0 = wr_reqs;
        mem_req_ready = 1'b0;
        cpu_addr = 32'h1010;
        cpu_we   = 4'hF;
        cpu_din  = 32'h1234_5678;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 32'(mem_req_valid), 32'd1);
            check("bp_stall", 32'(stall), 32'd1);
            check("bp_addr", mem_req_addr, 32'h1010);
            check("bp_data", mem_req_data, 32'h1234_5678);
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        cpu_we = '0;
        check("bp_release_stall", 32'(stall), 32'd0);
        check("bp_writes", 32'(wr_reqs - w0), 32'd1);

        cpu_addr = 32'h3000;
        cpu_re   = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_dout", cpu_dout, 32'd0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        cpu_re = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        r0 = rd_reqs;
        xact(32'h1004, 1'b1, 4'h0, 32'h0, st);
        check("post_rst_stall_cycles", 32'(st), 32'd6);
        check("post_rst_refills", 32'(rd_reqs - r0), 32'd1);
        check("post_rst_dout", cpu_dout, 32'h0000_BBA1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
